// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the instruction-fetch unit.
//   WordW          : datapath / address width
//   ResetPcDefault : default first-fetch address after reset
//   St*            : fetch FSM state encoding
package pc_fetch_pkg;

   localparam int unsigned WordW = 32;

   localparam logic [WordW-1:0] ResetPcDefault = 32'h0000_0000;

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StReq   = 2'd1;
   localparam logic [1:0] StHold  = 2'd2;
   localparam logic [1:0] StFlush = 2'd3;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection.
//   pc_i            : current fetch PC
//   branch_taken_i  : conditional branch resolved taken
//   jump_i          : unconditional jump resolved
//   redirect_pc4_i  : PC+4 of the resolving branch/jump
//   branch_offset_i : sign-extended word offset
//   jump_index_i    : j-format target field
//   pc_seq_o        : sequential next PC (pc + 4, wraps naturally)
//   target_o        : redirect target (jump wins over branch)
//   redirect_o      : a redirect is requested this cycle
module pc_next_sel
   import pc_fetch_pkg::*;
(
   input  logic [WordW-1:0] pc_i,
   input  logic             branch_taken_i,
   input  logic             jump_i,
   input  logic [WordW-1:0] redirect_pc4_i,
   input  logic [WordW-1:0] branch_offset_i,
   input  logic [25:0]      jump_index_i,
   output logic [WordW-1:0] pc_seq_o,
   output logic [WordW-1:0] target_o,
   output logic             redirect_o
);

   logic [WordW-1:0] branch_tgt;
   logic [WordW-1:0] jump_tgt;

   always_comb begin
      pc_seq_o   = pc_i + 32'd4;
      branch_tgt = redirect_pc4_i + (branch_offset_i << 2);
      jump_tgt   = {redirect_pc4_i[31:28], jump_index_i, 2'b00};
      redirect_o = jump_i | branch_taken_i;
      target_o   = jump_i ? jump_tgt : branch_tgt;
   end

endmodule

// File: rtl/pc_fetch.sv
// Instruction-fetch unit: issues one memory request per instruction, holds the
// returned word for decode and handles branch/jump redirects.
//   clock, reset         : clock and asynchronous active-low reset
//   branch_taken, jump   : redirect requests from the resolve stage
//   redirect_pc4, branch_offset, jump_index : redirect target operands
//   stall                : decode hazard hold
//   imem_req/addr/ack/data : instruction-memory handshake
//   instr, pc_plus4, instr_valid, instr_ready : decode handshake
module pc_fetch
   import pc_fetch_pkg::*;
#(
   parameter logic [WordW-1:0] RESET_PC = ResetPcDefault
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             branch_taken,
   input  logic             jump,
   input  logic [WordW-1:0] redirect_pc4,
   input  logic [WordW-1:0] branch_offset,
   input  logic [25:0]      jump_index,
   input  logic             stall,
   output logic             imem_req,
   output logic [WordW-1:0] imem_addr,
   input  logic             imem_ack,
   input  logic [WordW-1:0] imem_data,
   output logic [WordW-1:0] instr,
   output logic [WordW-1:0] pc_plus4,
   output logic             instr_valid,
   input  logic             instr_ready
);

   logic [1:0]       state_d, state_q;
   logic [WordW-1:0] pc_d, pc_q;
   logic [WordW-1:0] flush_addr_d, flush_addr_q;
   logic [WordW-1:0] instr_d, instr_q;
   logic [WordW-1:0] pc_plus4_d, pc_plus4_q;

   logic [WordW-1:0] pc_seq;
   logic [WordW-1:0] target;
   logic             redirect;

   pc_next_sel u_pc_next_sel (
      .pc_i            (pc_q),
      .branch_taken_i  (branch_taken),
      .jump_i          (jump),
      .redirect_pc4_i  (redirect_pc4),
      .branch_offset_i (branch_offset),
      .jump_index_i    (jump_index),
      .pc_seq_o        (pc_seq),
      .target_o        (target),
      .redirect_o      (redirect)
   );

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      flush_addr_d = flush_addr_q;
      instr_d      = instr_q;
      pc_plus4_d   = pc_plus4_q;
      case (state_q)
         StIdle: begin
            state_d = StReq;
            if (redirect) pc_d = target;
         end
         StReq: begin
            if (redirect) begin
               pc_d         = target;
               // Keep presenting the old address until the in-flight access returns.
               flush_addr_d = pc_q;
               state_d      = imem_ack ? StReq : StFlush;
            end else if (imem_ack) begin
               instr_d    = imem_data;
               pc_plus4_d = pc_seq;
               pc_d       = pc_seq;
               state_d    = StHold;
            end
         end
         StHold: begin
            if (redirect) begin
               pc_d    = target;
               state_d = StReq;
            end else if (instr_ready && !stall) begin
               state_d = StReq;
            end
         end
         StFlush: begin
            // Returned data is stale; only the PC tracks further redirects.
            if (redirect) pc_d = target;
            if (imem_ack) state_d = StReq;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= StIdle;
         pc_q         <= RESET_PC;
         flush_addr_q <= '0;
         instr_q      <= '0;
         pc_plus4_q   <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         flush_addr_q <= flush_addr_d;
         instr_q      <= instr_d;
         pc_plus4_q   <= pc_plus4_d;
      end
   end

   always_comb begin
      imem_req    = (state_q == StReq) || (state_q == StFlush);
      imem_addr   = '0;
      if (state_q == StReq)   imem_addr = pc_q;
      if (state_q == StFlush) imem_addr = flush_addr_q;
      instr       = instr_q;
      pc_plus4    = pc_plus4_q;
      instr_valid = (state_q == StHold);
   end

endmodule

// File: tb/tb_pc_fetch.sv
module tb_pc_fetch;

   logic        clock;
   logic        reset;
   logic        branch_taken;
   logic        jump;
   logic [31:0] redirect_pc4;
   logic [31:0] branch_offset;
   logic [25:0] jump_index;
   logic        stall;
   logic        imem_ack;
   logic [31:0] imem_data;
   logic        instr_ready;

   logic        imem_req,    imem_req2;
   logic [31:0] imem_addr,   imem_addr2;
   logic [31:0] instr,       instr2;
   logic [31:0] pc_plus4,    pc_plus42;
   logic        instr_valid, instr_valid2;

   pc_fetch u_dut (
      .clock         (clock),
      .reset         (reset),
      .branch_taken  (branch_taken),
      .jump          (jump),
      .redirect_pc4  (redirect_pc4),
      .branch_offset (branch_offset),
      .jump_index    (jump_index),
      .stall         (stall),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_data     (imem_data),
      .instr         (instr),
      .pc_plus4      (pc_plus4),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready)
   );

   // Second instance starting at the top of the address space; it runs in
   // lockstep with the first since the FSM ignores address values.
   pc_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
      .clock         (clock),
      .reset         (reset),
      .branch_taken  (branch_taken),
      .jump          (jump),
      .redirect_pc4  (redirect_pc4),
      .branch_offset (branch_offset),
      .jump_index    (jump_index),
      .stall         (stall),
      .imem_req      (imem_req2),
      .imem_addr     (imem_addr2),
      .imem_ack      (imem_ack),
      .imem_data     (imem_data),
      .instr         (instr2),
      .pc_plus4      (pc_plus42),
      .instr_valid   (instr_valid2),
      .instr_ready   (instr_ready)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc4;
   } sb_t;

   typedef struct {
      logic        bt;
      logic        jmp;
      logic [31:0] pc4;
      logic [31:0] off;
      logic [25:0] idx;
      logic [31:0] exp;
   } vec_t;

   sb_t  sb_q[$];
   vec_t vecs[6];
   int   checks = 0;
   int   errors = 0;
   logic prev_valid = 1'b0;
   logic chk2 = 1'b0;
   logic [31:0] exp_pc;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hDEAD_BEEF;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Advance to the next falling edge and run the scoreboard on a new instr.
   task automatic tick();
      sb_t e;
      @(negedge clock);
      if (instr_valid && !prev_valid) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: instr_valid=1 instr=%h, expected no instruction", instr);
         end else begin
            e = sb_q.pop_front();
            check("sb_instr", instr, e.instr);
            check("sb_pc_plus4", pc_plus4, e.pc4);
         end
      end
      prev_valid = instr_valid;
   endtask

   task automatic fetch(input logic [31:0] exp_addr, input int lat);
      sb_t e;
      int  n = 0;
      while (!imem_req && n < 20) begin
         tick();
         n++;
      end
      if (!imem_req) begin
         checks++;
         errors++;
         $display("FAIL fetch_timeout: imem_req=0, expected request for %h", exp_addr);
         return;
      end
      check("fetch_addr", imem_addr, exp_addr);
      if (chk2) check("wrap_addr", imem_addr2, exp_addr + 32'hFFFF_FFFC);
      for (int i = 0; i < lat; i++) begin
         tick();
         check("req_held", 32'(imem_req), 32'd1);
         check("addr_stable", imem_addr, exp_addr);
      end
      imem_ack  = 1'b1;
      imem_data = mem_word(exp_addr);
      e.instr   = mem_word(exp_addr);
      e.pc4     = exp_addr + 32'd4;
      sb_q.push_back(e);
      tick();
      imem_ack  = 1'b0;
   endtask

   task automatic clear_redirect();
      branch_taken  = 1'b0;
      jump          = 1'b0;
      redirect_pc4  = '0;
      branch_offset = '0;
      jump_index    = '0;
   endtask

   initial begin
      vecs[0] = '{bt: 1'b1, jmp: 1'b0, pc4: 32'h0000_0010, off: 32'hFFFF_FFFE, idx: 26'h0,
                  exp: 32'h0000_0008};
      vecs[1] = '{bt: 1'b1, jmp: 1'b0, pc4: 32'h0000_0010, off: 32'h0000_0003, idx: 26'h0,
                  exp: 32'h0000_001C};
      vecs[2] = '{bt: 1'b1, jmp: 1'b1, pc4: 32'h4000_0010, off: 32'h0000_0005, idx: 26'h40,
                  exp: 32'h4000_0100};
      vecs[3] = '{bt: 1'b0, jmp: 1'b1, pc4: 32'hF000_0004, off: 32'h0, idx: 26'h3FF_FFFF,
                  exp: 32'hFFFF_FFFC};
      vecs[4] = '{bt: 1'b1, jmp: 1'b0, pc4: 32'hFFFF_FFF0, off: 32'h0000_0008, idx: 26'h0,
                  exp: 32'h0000_0010};
      vecs[5] = '{bt: 1'b1, jmp: 1'b0, pc4: 32'h0000_0100, off: 32'hFFFF_FFBF, idx: 26'h0,
                  exp: 32'hFFFF_FFFC};

      reset       = 1'b0;
      stall       = 1'b0;
      imem_ack    = 1'b0;
      imem_data   = '0;
      instr_ready = 1'b1;
      clear_redirect();

      // Reset state.
      tick();
      tick();
      check("rst_req", 32'(imem_req), 32'd0);
      check("rst_addr", imem_addr, 32'd0);
      check("rst_instr", instr, 32'd0);
      check("rst_pc_plus4", pc_plus4, 32'd0);
      check("rst_valid", 32'(instr_valid), 32'd0);
      check("rst_addr_wrap", imem_addr2, 32'd0);
      reset = 1'b1;

      // Straight-line fetch; the wrap instance goes FFFF_FFFC -> 0 -> 4.
      chk2 = 1'b1;
      fetch(32'h0, 1);
      fetch(32'h4, 1);
      fetch(32'h8, 1);
      chk2 = 1'b0;
      tick();
      instr_ready = 1'b0;

      // Redirect targets from HOLD.
      exp_pc = 32'hC;
      for (int v = 0; v < 6; v++) begin
         fetch(exp_pc, 0);
         check("hold_valid", 32'(instr_valid), 32'd1);
         branch_taken  = vecs[v].bt;
         jump          = vecs[v].jmp;
         redirect_pc4  = vecs[v].pc4;
         branch_offset = vecs[v].off;
         jump_index    = vecs[v].idx;
         tick();
         clear_redirect();
         check("redir_valid_drop", 32'(instr_valid), 32'd0);
         exp_pc = vecs[v].exp;
      end
      fetch(exp_pc, 0);

      // Redirect while a request is outstanding.
      branch_taken  = 1'b1;
      redirect_pc4  = 32'h10;
      branch_offset = 32'hFFFF_FFFE;
      tick();
      check("req_at_8", imem_addr, 32'h8);
      branch_offset = 32'h4;
      tick();
      clear_redirect();
      for (int i = 0; i < 3; i++) begin
         check("flush_req", 32'(imem_req), 32'd1);
         check("flush_old_addr", imem_addr, 32'h8);
         check("flush_valid", 32'(instr_valid), 32'd0);
         tick();
      end
      imem_ack  = 1'b1;
      imem_data = 32'h0BAD_0BAD;
      tick();
      imem_ack  = 1'b0;
      check("after_flush_addr", imem_addr, 32'h20);
      check("after_flush_valid", 32'(instr_valid), 32'd0);

      // Redirect coinciding with the ack: data dropped, refetch at target.
      imem_ack   = 1'b1;
      imem_data  = 32'h0BAD_0BAD;
      jump       = 1'b1;
      jump_index = 26'h30;
      tick();
      imem_ack = 1'b0;
      clear_redirect();
      check("same_cycle_addr", imem_addr, 32'hC0);
      check("same_cycle_valid", 32'(instr_valid), 32'd0);
      fetch(32'hC0, 0);

      // Stall overrides instr_ready and freezes HOLD.
      stall       = 1'b1;
      instr_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("stall_valid", 32'(instr_valid), 32'd1);
         check("stall_instr", instr, mem_word(32'hC0));
         check("stall_pc_plus4", pc_plus4, 32'hC4);
         check("stall_no_req", 32'(imem_req), 32'd0);
      end
      branch_taken  = 1'b1;
      redirect_pc4  = 32'h100;
      branch_offset = 32'h0;
      tick();
      clear_redirect();
      stall = 1'b0;
      check("stall_redir_valid", 32'(instr_valid), 32'd0);
      check("stall_redir_addr", imem_addr, 32'h100);
      fetch(32'h100, 1);

      // Reset asserted mid-request.
      for (int n = 0; n < 5 && !imem_req; n++) tick();
      check("pre_reset_req", 32'(imem_req), 32'd1);
      #2 reset = 1'b0;
      #1;
      check("async_rst_req", 32'(imem_req), 32'd0);
      check("async_rst_addr", imem_addr, 32'd0);
      check("async_rst_wrap_req", 32'(imem_req2), 32'd0);
      tick();
      reset     = 1'b1;
      imem_ack  = 1'b1;
      imem_data = 32'h0BAD_0BAD;
      tick();
      imem_ack = 1'b0;
      check("stale_ack_valid", 32'(instr_valid), 32'd0);
      chk2 = 1'b1;
      fetch(32'h0, 1);
      chk2 = 1'b0;
      tick();

      check("sb_drained", sb_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the address of the first instruction fetched after reset.
REQ-002 clock  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  asynchronous, active-low; SHALL clear all state immediately when low.
REQ-004 branch_taken  in  1  branch-decision result from the branch AND stage (beq/bne taken).
REQ-005 jump  in  1  unconditional jump (j) resolved this cycle.
REQ-006 redirect_pc4  in  32  PC+4 of the resolving branch/jump instruction.
REQ-007 branch_offset  in  32  sign-extended immediate, word units.
REQ-008 jump_index  in  26  j-format target field.
REQ-009 stall  in  1  hazard hold from decode.
REQ-010 imem_req  out  1  instruction-memory request.
REQ-011 imem_addr  out  32  instruction-memory address.
REQ-012 imem_ack  in  1  memory returns imem_data this cycle.
REQ-013 imem_data  in  32  instruction word.
REQ-014 instr  out  32  fetched instruction to decode.
REQ-015 pc_plus4  out  32  PC+4 of instr.
REQ-016 instr_valid  out  1  instr/pc_plus4 valid.
REQ-017 instr_ready  in  1  decode accepts instr this cycle.

Function
REQ-018 Branch target SHALL be redirect_pc4 + (branch_offset << 2), modulo 2^32.
REQ-019 Jump target SHALL be {redirect_pc4[31:28], jump_index, 2'b00}.
REQ-020 If jump and branch_taken are both high, the jump target SHALL win.
REQ-021 Sequential next PC SHALL be pc + 4, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-022 States: IDLE, REQ, HOLD, FLUSH.
REQ-023 IDLE: outputs quiet; next cycle -> REQ.
REQ-024 REQ: imem_req=1, imem_addr=pc; on imem_ack, instr<=imem_data, pc_plus4<=pc+4, pc<=pc+4, -> HOLD.
REQ-025 imem_addr SHALL stay stable while imem_req=1 until imem_ack.
REQ-026 HOLD: instr_valid=1; instr and pc_plus4 stable; on instr_ready=1 and stall=0 -> REQ next cycle.
REQ-027 stall=1 SHALL override instr_ready and hold HOLD unchanged.
REQ-028 Redirect (jump or branch_taken) SHALL set pc<=target, taking priority over stall.
REQ-029 Redirect in IDLE or HOLD -> REQ; instr_valid SHALL drop the next cycle.
REQ-030 Redirect in REQ with imem_ack the same cycle: returned data discarded -> REQ at target.
REQ-031 Redirect in REQ without imem_ack -> FLUSH; imem_req and the old imem_addr are held.
REQ-032 FLUSH: on imem_ack, data discarded -> REQ at pc; a further redirect only updates pc.
REQ-033 Fetch latency: address to instr_valid = 1 cycle after imem_ack; max throughput 1 instruction per 2 cycles.

Reset
REQ-034 On reset low: state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=0, instr=0, pc_plus4=0, instr_valid=0.
REQ-035 Reset mid-fetch SHALL abandon the outstanding request; an imem_ack arriving after release with no request pending SHALL be ignored.

Structure
REQ-036 Shared package pc_fetch_pkg SHALL hold the state encoding, the RESET_PC default and the 32-bit word-width constant.
REQ-037 Next-PC computation (REQ-018..021) SHALL be a combinational sub-module pc_next_sel.

Verification
REQ-038 Reset release, imem_ack one cycle after each imem_req, instr_ready=1 -> imem_addr 0x0, 0x4, 0x8; pc_plus4 0x4, 0x8, 0xC.
REQ-039 Branch at redirect_pc4=0x10, offset=-2 -> next imem_addr=0x08; offset=3 -> 0x1C.
REQ-040 jump=1 and branch_taken=1, redirect_pc4=0x4000_0010, jump_index=0x40 -> imem_addr=0x4000_0100.
REQ-041 Redirect to 0x20 in REQ at 0x8, imem_ack 3 cycles later -> data discarded, no instr_valid, then imem_addr=0x20.
REQ-042 HOLD with stall=1 for 4 cycles -> instr stable, no imem_req; redirect during stall -> instr_valid drops, fetch at target.
REQ-043 RESET_PC=0xFFFF_FFFC -> second fetch at 0x0000_0000; reset asserted mid-REQ -> imem_req=0 immediately, fetch restarts at RESET_PC.
